// File: rtl/sram_req_arbiter.sv
// ============================================================================
// Module  : sram_req_arbiter
// Purpose : Shares one SRAM-like master port between fetch and data requesters,
//           tracking accepted transactions in an in-order ID FIFO.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sram_req_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [1:0]          inst_size,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                m_req,
    output logic                m_wr,
    output logic [1:0]          m_size,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int              PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int              CNT_W    = $clog2(OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [OUTSTANDING-1:0] id_q;

    logic gnt_i;
    logic gnt_d;
    logic full;
    logic accept;
    logic complete;
    logic head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign full = (count_q == CNT_FULL);

    // Fixed priority only when idle; a locked grant follows its owner's request alone.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!full) begin
                    if (data_req)      gnt_d = 1'b1;
                    else if (inst_req) gnt_i = 1'b1;
                end
            end
            ST_LOCK_I: gnt_i = inst_req;
            ST_LOCK_D: gnt_d = data_req;
            default: begin
                gnt_i = 1'b0;
                gnt_d = 1'b0;
            end
        endcase
    end

    assign m_req    = !reset && !full && (gnt_i || gnt_d);
    assign accept   = m_req && m_addr_ok;
    assign complete = !reset && m_data_ok && (count_q != '0);
    assign head_id  = id_q[rptr_q];

    assign inst_addr_ok = accept && gnt_i;
    assign data_addr_ok = accept && gnt_d;
    assign inst_data_ok = complete && !head_id;
    assign data_data_ok = complete &&  head_id;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    // The fetch path never writes, so its write-side payload is forced to zero.
    always_comb begin
        m_wr    = 1'b0;
        m_size  = 2'd0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (gnt_d) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_wdata = data_wdata;
        end else if (gnt_i) begin
            m_size  = inst_size;
            m_addr  = inst_addr;
        end
    end

    always_comb begin
        count_d = count_q;
        wptr_d  = accept   ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = complete ? ptr_inc(rptr_q) : rptr_q;
        case ({accept, complete})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (m_req && !m_addr_ok) begin
            state_q <= gnt_d ? ST_LOCK_D : ST_LOCK_I;
        end else begin
            state_q <= ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            id_q    <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            if (accept) begin
                id_q[wptr_q] <= gnt_d;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
// ============================================================================
// Module  : tb_sram_req_arbiter
// Purpose : Self-checking bench for sram_req_arbiter (vector table + sequences).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_req_arbiter;

    localparam logic [31:0] IADDR = 32'h1c00_0000;
    localparam logic [31:0] DADDR = 32'h0000_0010;
    localparam logic [31:0] WDATA = 32'hdead_beef;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [1:0]  inst_size;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;
    logic sb[$];

    sram_req_arbiter #(.OUTSTANDING(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs after the edge, sample at the falling edge and
    // retire the scoreboard head when a completion is offered.
    task automatic cyc(input logic ir, input logic dr, input logic dw,
                       input logic aok, input logic dok, input logic [31:0] rd);
        logic e;
        @(posedge clk); #1;
        inst_req = ir; data_req = dr; data_wr = dw;
        m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
        @(negedge clk);
        if (dok && sb.size() != 0) begin
            e = sb.pop_front();
            chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, !e});
            chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, e});
            chk("rdata", e ? data_rdata : inst_rdata, rd);
        end else begin
            chk("no_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        end
    endtask

    // Address-phase checks; expected accepts enter the scoreboard.
    task automatic aphase(input logic ereq, input logic eiok, input logic edok);
        chk("m_req",        {31'd0, m_req},        {31'd0, ereq});
        chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, eiok});
        chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, edok});
        if (edok)      sb.push_back(1'b1);
        else if (eiok) sb.push_back(1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 && sb.size() != 0; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, $urandom);
        end
        chk("drained", sb.size(), 32'd0);
    endtask

    typedef struct {
        logic        ir, dr, dw, aok;
        logic        e_mreq, e_iok, e_dok, e_wr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IADDR};
        vt[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, DADDR};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, DADDR};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DADDR};
        vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IADDR};

        reset = 1'b1;
        inst_req = 1'b1; inst_addr = IADDR; inst_size = 2'd2;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = DADDR; data_wdata = WDATA;
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1234_5678;

        // Outputs held low while reset is asserted, whatever the inputs.
        @(negedge clk);
        chk("rst_m_req",   {31'd0, m_req}, 32'd0);
        chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        @(posedge clk); #1;
        inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            cyc(vt[i].ir, vt[i].dr, vt[i].dw, vt[i].aok, 1'b0, 32'd0);
            aphase(vt[i].e_mreq, vt[i].e_iok, vt[i].e_dok);
            if (vt[i].e_mreq) begin
                chk($sformatf("v%0d_m_addr", i), m_addr, vt[i].e_addr);
                chk($sformatf("v%0d_m_wr", i), {31'd0, m_wr}, {31'd0, vt[i].e_wr});
            end
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            drain();
        end

        // Fetch alone: zero write payload, data returned two cycles later.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        aphase(1'b1, 1'b1, 1'b0);
        chk("f_m_addr",  m_addr, IADDR);
        chk("f_payload", {m_wr, m_wstrb, m_wdata[26:0]}, 32'd0);
        chk("f_m_wdata", m_wdata, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0280_0000);

        // Simultaneous requests: store first, fetch accepted next cycle.
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        aphase(1'b1, 1'b0, 1'b1);
        chk("s_m_wr",    {31'd0, m_wr}, 32'd1);
        chk("s_m_wstrb", {28'd0, m_wstrb}, 32'hf);
        chk("s_m_wdata", m_wdata, WDATA);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00aa);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00bb);

        // Locked fetch grant survives a later data request.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        aphase(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
            aphase(1'b1, 1'b0, 1'b0);
            chk("lock_m_addr", m_addr, IADDR);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        aphase(1'b1, 1'b1, 1'b0);
        chk("lock_acc_addr", m_addr, IADDR);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        aphase(1'b1, 1'b0, 1'b1);
        chk("after_lock_addr", m_addr, DADDR);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        drain();

        // Full FIFO blocks grants, even alongside a completion.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0001); aphase(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0002);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0003); aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        drain();

        // Completion with nothing outstanding is ignored and leaves count at zero.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0bad);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b0, 1'b0, 1'b0);

        // Asynchronous reset with two outstanding discards them.
        @(posedge clk); #1;
        reset = 1'b1; sb.delete();
        inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_req",   {31'd0, m_req}, 32'd0);
        chk("mid_rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("mid_rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        @(posedge clk); #1;
        inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0bad);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0); aphase(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
